// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// A WIDTH-bit word is sent LSB-first between one start bit (0) and one
// stop bit (1); every serial bit is held for CLK_PER_BIT clock cycles.
// All outputs come straight from flops, so nothing on d_in/load reaches
// ser_out/busy/done without passing through a clock edge.

module serial_frame_tx #(
    parameter int WIDTH       = 8,   // data bits per frame, 1..32
    parameter int CLK_PER_BIT = 4    // cycles each serial bit is held, >= 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    // Counter widths never drop below one bit so WIDTH=1 and
    // CLK_PER_BIT=1 still produce legal vectors.
    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] LAST_BAUD = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state,    state_nxt;
    logic [WIDTH-1:0] shreg,    shreg_nxt;
    logic [BW-1:0]    bit_cnt,  bit_nxt;
    logic [CW-1:0]    baud_cnt, baud_nxt;
    logic             ser_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             bit_end;

    // The current serial bit has been held for its last cycle.
    assign bit_end = (baud_cnt == LAST_BAUD);

    // State register plus the registered datapath and outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: the shift register is reset as well; it is a handful of
            // flops, not a memory, and a known value keeps aborts clean.
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            ser_out  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_nxt;
            baud_cnt <= baud_nxt;
            ser_out  <= ser_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state and next-output decode; outputs are computed one edge
    // ahead so the line changes on the same edge the state does.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        baud_nxt  = baud_cnt;
        ser_nxt   = ser_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                ser_nxt  = 1'b1;
                busy_nxt = 1'b0;
                // load is only looked at here, so a load (or an unknown
                // load) during a frame cannot disturb it.
                if (load) begin
                    shreg_nxt = d_in;
                    state_nxt = S_START;
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                    ser_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                    ser_nxt   = shreg[0];
                end else begin
                    baud_nxt = baud_cnt + BAUD_ONE;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = S_STOP;
                        ser_nxt   = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + BIT_ONE;
                        ser_nxt = shreg_nxt[0];
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_ONE;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                    ser_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + BAUD_ONE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                baud_nxt  = '0;
                bit_nxt   = '0;
                ser_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed self-checking bench for serial_frame_tx.
// Main instance: WIDTH=8, CLK_PER_BIT=4. Corner instance: WIDTH=1,
// CLK_PER_BIT=1. Outputs are sampled on the falling edge; inputs are
// changed on the falling edge too, so they are stable at each rising edge.
// Log index k means "sampled after the k-th rising edge following the
// load edge" (k=0 is right after the load edge).

module tb_serial_frame_tx;

    logic       clk;
    logic       clr;
    logic [7:0] d_in;
    logic       load;
    logic       ser_out;
    logic       busy;
    logic       done;

    logic [0:0] d_c;
    logic       load_c;
    logic       ser_c;
    logic       busy_c;
    logic       done_c;

    int checks = 0;
    int errors = 0;

    logic s_log [0:127];
    logic b_log [0:127];
    logic d_log [0:127];

    serial_frame_tx #(.WIDTH(8), .CLK_PER_BIT(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .d_in    (d_in),
        .load    (load),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    serial_frame_tx #(.WIDTH(1), .CLK_PER_BIT(1)) dut_c (
        .clk     (clk),
        .clr     (clr),
        .d_in    (d_c),
        .load    (load_c),
        .ser_out (ser_c),
        .busy    (busy_c),
        .done    (done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Log the main instance for one cycle at index k.
    task automatic log_cycle(input int k);
        s_log[k] = ser_out;
        b_log[k] = busy;
        d_log[k] = done;
    endtask

    // vec[j] is serial slot j: slot 0 = start bit, 1..8 = data LSB-first,
    // 9 = stop bit. Each slot spans 4 cycles, then done at base+40.
    task automatic check_frame(input string name, input logic [9:0] vec, input int base);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_ser_s%0d_c%0d", name, j, c), 32'(s_log[base + 4*j + c]), 32'(vec[j]));
                check($sformatf("%s_busy_s%0d_c%0d", name, j, c), 32'(b_log[base + 4*j + c]), 32'd1);
            end
        end
        check($sformatf("%s_done_end", name), 32'(d_log[base + 40]), 32'd1);
        check($sformatf("%s_busy_end", name), 32'(b_log[base + 40]), 32'd0);
        check($sformatf("%s_ser_end", name), 32'(s_log[base + 40]), 32'd1);
    endtask

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (d_log[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (b_log[k] === 1'b1) n++;
        return n;
    endfunction

    logic [5:0] c_ser;
    logic [5:0] c_busy;
    logic [5:0] c_done;

    initial begin
        clr    = 1'b1;
        load   = 1'b0;
        d_in   = 8'h00;
        load_c = 1'b0;
        d_c    = 1'b0;

        // Reset takes effect before any rising edge.
        #1;
        check("rst_ser", 32'(ser_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_c_ser", 32'(ser_c), 32'd1);
        check("rst_c_busy", 32'(busy_c), 32'd0);

        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ser", 32'(ser_out), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic frame 8'hA5 = 1010_0101 -> slots 0,1,0,1,0,0,1,0,1,1.
        d_in = 8'hA5;
        load = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 0) begin
                load = 1'b0;
                d_in = 8'h00;  // changes after the load edge must not matter
            end
            log_cycle(k);
        end
        check_frame("a5", 10'b1101001010, 0);
        check("a5_busy_cycles", 32'(count_busy(0, 44)), 32'd40);
        check("a5_done_count", 32'(count_done(0, 44)), 32'd1);

        // Frame 8'h3C with a load of 8'hFF at cycle 10 and an unknown
        // load at cycle 20; both land while busy and must be ignored.
        // 8'h3C = 0011_1100 -> data LSB-first 0,0,1,1,1,1,0,0.
        d_in = 8'h3C;
        load = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) load = 1'b0;
            if (k == 9) begin
                load = 1'b1;
                d_in = 8'hFF;
            end
            if (k == 10) load = 1'b0;
            if (k == 19) load = 1'bx;
            if (k == 20) load = 1'b0;
            log_cycle(k);
        end
        check_frame("3c", 10'b1001111000, 0);
        check("3c_busy_cycles", 32'(count_busy(0, 59)), 32'd40);
        check("3c_done_count", 32'(count_done(0, 59)), 32'd1);

        // Back-to-back: load held high, 8'h00 then 8'hFF. The first frame
        // finishes at edge 40 (IDLE, done=1); the held load is accepted on
        // the following edge, so the second frame starts at index 41 and
        // its done pulse comes 40 cycles later at index 81.
        d_in = 8'h00;
        load = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (k == 0) d_in = 8'hFF;
            if (k == 41) load = 1'b0;
            log_cycle(k);
        end
        check_frame("b2b_00", 10'b1000000000, 0);
        check_frame("b2b_ff", 10'b1111111110, 41);
        check("b2b_done_count", 32'(count_done(0, 89)), 32'd2);
        check("b2b_busy_cycles", 32'(count_busy(0, 89)), 32'd80);

        // Reset mid-frame: 8'h81 = 1000_0001; index 16 is slot 4 = data bit 3 = 0.
        d_in = 8'h81;
        load = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 0) load = 1'b0;
            log_cycle(k);
        end
        check("abort_pre_busy", 32'(b_log[16]), 32'd1);
        check("abort_pre_ser", 32'(s_log[16]), 32'd0);
        clr = 1'b1;
        #1;
        check("abort_ser", 32'(ser_out), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        #1;
        clr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            log_cycle(k);
        end
        check("abort_after_done", 32'(count_done(0, 9)), 32'd0);
        check("abort_after_busy", 32'(count_busy(0, 9)), 32'd0);
        check("abort_after_ser", 32'(s_log[9]), 32'd1);

        // Fresh frame after the abort: 8'h6B = 0110_1011.
        d_in = 8'h6B;
        load = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 0) load = 1'b0;
            log_cycle(k);
        end
        check_frame("6b", 10'b1011010110, 0);
        check("6b_done_count", 32'(count_done(0, 44)), 32'd1);

        // Corner WIDTH=1, CLK_PER_BIT=1, d=1: ser 0,1,1 then done at index 3.
        c_ser  = 6'b111110;
        c_busy = 6'b000111;
        c_done = 6'b001000;
        d_c    = 1'b1;
        load_c = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) load_c = 1'b0;
            check($sformatf("corner_ser_%0d", k), 32'(ser_c), 32'(c_ser[k]));
            check($sformatf("corner_busy_%0d", k), 32'(busy_c), 32'(c_busy[k]));
            check($sformatf("corner_done_%0d", k), 32'(done_c), 32'(c_done[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
